// File: rtl/branch_predictor_pkg.sv
// Shared CPU definitions used by the branch predictor. This file holds the
// 2-bit counter encodings, the RISC-V control-flow opcodes and the
// sequential PC increment.
package branch_predictor_pkg;

   // 2-bit saturating counter states. The MSB is the taken prediction.
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,   // strong not-taken
      CTR_WNT = 2'b01,   // weak not-taken
      CTR_WT  = 2'b10,   // weak taken
      CTR_ST  = 2'b11    // strong taken
   } ctr_e;

   // RISC-V opcodes of the instructions that update the predictor
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Sequential fetch step. Arithmetic wraps modulo 2^32.
   localparam logic [31:0] PC_INC = 32'd4;

   // A counter predicts taken whenever it is in one of the upper two states
   function automatic logic ctr_taken(input ctr_e c);
      return c[1];
   endfunction

endpackage

// File: rtl/bp_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module bp_counter2
   import branch_predictor_pkg::*;
(
   input  ctr_e cur,
   input  logic taken,
   output ctr_e next
);

   // Step the counter toward the resolved direction, saturating at both ends
   always_comb begin
      next = cur;
      unique case (cur)
         CTR_SNT: next = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: next = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  next = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  next = taken ? CTR_ST  : CTR_WT;
         default: next = cur;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch looks up pcF combinationally; execute resolves the prediction that
// travelled down the pipe and trains the table on the next rising edge.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   // fetch-stage lookup
   input  logic [31:0] pcF,
   output logic        pred_takenF,
   output logic [31:0] pred_targetF,
   // execute-stage resolution
   input  logic        validE,
   input  logic        is_ctrlE,
   input  logic [31:0] pcE,
   input  logic        br_selE,
   input  logic [31:0] targetE,
   input  logic        pred_takenE,
   input  logic [31:0] pred_targetE,
   output logic        mispredictE,
   output logic [31:0] redirect_pcE
);

   localparam int IDX_W = $clog2(ENTRIES);

   // Entry storage: flop arrays. Only valid and counter are control state
   // and see reset; tag and target are qualified by valid.
   logic             valid_q [ENTRIES];
   ctr_e             ctr_q   [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [29:0]      tgt_q   [ENTRIES];

   logic [IDX_W-1:0] idxF, idxE;
   logic [TAG_W-1:0] tagF, tagE;
   logic             hitF, hitE;
   logic             actualE;
   logic [31:0]      seqF, seqE;

   logic             wr_alloc_d;
   logic             wr_data_d;
   logic             ctr_step_d;
   logic             inval_d;
   ctr_e             ctr_cur;
   ctr_e             ctr_nxt;

   // Index/tag extraction for both lookup ports
   always_comb begin
      idxF = pcF[IDX_W+1:2];
      tagF = pcF[TAG_W+5:6];
      idxE = pcE[IDX_W+1:2];
      tagE = pcE[TAG_W+5:6];
      seqF = pcF + PC_INC;
      seqE = pcE + PC_INC;
   end

   // Fetch lookup; reads the current table, so a same-cycle update is not seen
   always_comb begin
      hitF         = valid_q[idxF] && (tag_q[idxF] == tagF);
      pred_takenF  = hitF && ctr_taken(ctr_q[idxF]);
      pred_targetF = pred_takenF ? {tgt_q[idxF], 2'b00} : seqF;
   end

   // Execute resolution: any disagreement in direction, or in target for a
   // taken transfer, redirects fetch in the same cycle
   always_comb begin
      actualE      = is_ctrlE && br_selE;
      hitE         = valid_q[idxE] && (tag_q[idxE] == tagE);
      mispredictE  = validE &&
                     ((pred_takenE != actualE) ||
                      (actualE && (pred_targetE != targetE)));
      redirect_pcE = br_selE ? targetE : seqE;
   end

   // Training decisions for the entry addressed by pcE
   always_comb begin
      wr_alloc_d = validE && is_ctrlE && actualE && !hitE;
      wr_data_d  = validE && is_ctrlE && actualE;
      ctr_step_d = validE && is_ctrlE && hitE;
      inval_d    = validE && !is_ctrlE && hitE;
      ctr_cur    = ctr_q[idxE];
   end

   bp_counter2 u_ctr (
      .cur   (ctr_cur),
      .taken (actualE),
      .next  (ctr_nxt)
   );

   // Control state: valid bits and counters; reset wins over any update
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_WNT;
         end
      end else begin
         if (wr_alloc_d) begin
            valid_q[idxE] <= 1'b1;
            ctr_q[idxE]   <= CTR_WT;
         end else if (ctr_step_d) begin
            ctr_q[idxE]   <= ctr_nxt;
         end
         if (inval_d) begin
            valid_q[idxE] <= 1'b0;
         end
      end
   end

   // Payload: tag and target written on every taken control transfer
   always_ff @(posedge clk) begin
      if (!rst && wr_data_d) begin
         tag_q[idxE] <= tagE;
         tgt_q[idxE] <= targetE[31:2];
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed sequence with literal expectations
// plus a table-level model compared on every falling edge.
module tb_branch_predictor;

   localparam int ENTRIES = 16;
   localparam int TAG_W   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcF;
   logic        pred_takenF;
   logic [31:0] pred_targetF;
   logic        validE, is_ctrlE, br_selE, pred_takenE;
   logic [31:0] pcE, targetE, pred_targetE;
   logic        mispredictE;
   logic [31:0] redirect_pcE;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .pcF          (pcF),
      .pred_takenF  (pred_takenF),
      .pred_targetF (pred_targetF),
      .validE       (validE),
      .is_ctrlE     (is_ctrlE),
      .pcE          (pcE),
      .br_selE      (br_selE),
      .targetE      (targetE),
      .pred_takenE  (pred_takenE),
      .pred_targetE (pred_targetE),
      .mispredictE  (mispredictE),
      .redirect_pcE (redirect_pcE)
   );

   always #5 clk = ~clk;

   // ---------------- model: a table of plain records ----------------
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic int unsigned m_tagof(input logic [31:0] pc);
      return (pc / 64) % (1 << TAG_W);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
   endfunction

   always @(posedge clk) begin
      int  i;
      bit  h;
      i = m_idx(pcE);
      h = m_hit(pcE);
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = 1;
         end
      end else if (validE) begin
         if (is_ctrlE && br_selE) begin
            if (h) begin
               m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            end else begin
               m_valid[i] = 1'b1;
               m_tag[i]   = m_tagof(pcE);
               m_ctr[i]   = 2;
            end
            m_tgt[i] = targetE & 32'hFFFF_FFFC;
         end else if (is_ctrlE) begin
            if (h) m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end else if (h) begin
            m_valid[i] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      bit          tk;
      logic [31:0] tg;
      bit          act;
      bit          mp;
      if (chk_en) begin
         tk  = m_hit(pcF) && (m_ctr[m_idx(pcF)] >= 2);
         tg  = tk ? m_tgt[m_idx(pcF)] : pcF + 32'd4;
         act = is_ctrlE && br_selE;
         mp  = validE && ((pred_takenE != act) || (act && pred_targetE != targetE));
         chk("model_pred_takenF", {31'd0, pred_takenF}, {31'd0, tk});
         chk("model_pred_targetF", pred_targetF, tg);
         chk("model_mispredictE", {31'd0, mispredictE}, {31'd0, mp});
         chk("model_redirect_pcE", redirect_pcE, br_selE ? targetE : pcE + 32'd4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_e();
      validE = 0; is_ctrlE = 0; br_selE = 0; pred_takenE = 0;
      pcE = 32'h0; targetE = 32'h0; pred_targetE = 32'h0;
   endtask

   task automatic exec(input logic ctrl, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      validE = 1; is_ctrlE = ctrl; pcE = pc; br_selE = tk; targetE = tgt;
      pred_takenE = ptk; pred_targetE = ptgt;
   endtask

   logic [31:0] pcs [6];

   initial begin
      pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h104;
      pcs[3] = 32'h200; pcs[4] = 32'h240; pcs[5] = 32'h108;
      rst = 1; pcF = 32'h100; idle_e();
      tick(); tick();
      rst = 0;
      chk_en = 1;
      #1;
      // reset state: lookups miss
      chk("reset_takenF", {31'd0, pred_takenF}, 32'd0);
      chk("reset_targetF", pred_targetF, 32'h104);
      chk("reset_mispredictE", {31'd0, mispredictE}, 32'd0);

      // first taken branch, predicted not-taken; lookup same cycle sees old state
      exec(1, 32'h100, 1, 32'h80, 0, 32'h0);
      #1;
      chk("first_mispredict", {31'd0, mispredictE}, 32'd1);
      chk("first_redirect", redirect_pcE, 32'h80);
      chk("same_cycle_old_state", {31'd0, pred_takenF}, 32'd0);
      tick();
      idle_e();
      #1;
      chk("alloc_takenF", {31'd0, pred_takenF}, 32'd1);
      chk("alloc_targetF", pred_targetF, 32'h80);

      // two more taken (10->11->11), then one not-taken (->10)
      exec(1, 32'h100, 1, 32'h80, 1, 32'h80);
      #1;
      chk("correct_pred_no_mp", {31'd0, mispredictE}, 32'd0);
      tick(); tick();
      exec(1, 32'h100, 0, 32'h80, 1, 32'h80);
      #1;
      chk("nt_mispredict", {31'd0, mispredictE}, 32'd1);
      chk("nt_redirect", redirect_pcE, 32'h104);
      tick();
      idle_e();
      #1;
      chk("weak_taken_still_taken", {31'd0, pred_takenF}, 32'd1);
      exec(1, 32'h100, 0, 32'h80, 1, 32'h80);
      tick(); tick();
      idle_e();
      #1;
      chk("weakened_not_taken", {31'd0, pred_takenF}, 32'd0);
      chk("weakened_targetF", pred_targetF, 32'h104);

      // aliasing replacement: 0x140 shares index with 0x100
      exec(1, 32'h140, 1, 32'h200, 0, 32'h0);
      tick();
      idle_e();
      #1;
      chk("alias_old_misses", {31'd0, pred_takenF}, 32'd0);
      pcF = 32'h140;
      #1;
      chk("alias_new_taken", {31'd0, pred_takenF}, 32'd1);
      chk("alias_new_target", pred_targetF, 32'h200);

      // target mismatch with correct direction
      exec(1, 32'h308, 1, 32'h80, 1, 32'h80);
      #1;
      chk("tgt_match_no_mp", {31'd0, mispredictE}, 32'd0);
      targetE = 32'h84;
      #1;
      chk("tgt_mismatch_mp", {31'd0, mispredictE}, 32'd1);
      chk("tgt_mismatch_redirect", redirect_pcE, 32'h84);
      validE = 0;
      #1;
      chk("bubble_no_mp", {31'd0, mispredictE}, 32'd0);

      // non-control instruction hitting an entry invalidates it
      exec(0, 32'h140, 0, 32'h0, 1, 32'h200);
      #1;
      chk("nonctrl_mp", {31'd0, mispredictE}, 32'd1);
      chk("nonctrl_redirect", redirect_pcE, 32'h144);
      tick();
      idle_e();
      #1;
      chk("nonctrl_invalidated", {31'd0, pred_takenF}, 32'd0);

      // PC wrap
      pcF = 32'hFFFF_FFFC;
      exec(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
      #1;
      chk("wrap_targetF", pred_targetF, 32'h0);
      chk("wrap_redirect", redirect_pcE, 32'h0);
      chk("wrap_no_mp", {31'd0, mispredictE}, 32'd0);
      tick();

      // mixed traffic checked by the model
      for (int n = 0; n < 60; n++) begin
         logic [31:0] p;
         p = pcs[$urandom_range(0, 5)];
         pcF = pcs[$urandom_range(0, 5)];
         exec(1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 1)),
              32'h400 + 32'($urandom_range(0, 3)) * 4,
              m_hit(p) && m_ctr[m_idx(p)] >= 2, m_tgt[m_idx(p)]);
         validE = 1'($urandom_range(0, 4) != 0);
         tick();
      end

      // train 0x200, then reset mid-stream with a pending update
      exec(1, 32'h200, 1, 32'h500, 0, 32'h0);
      tick();
      exec(1, 32'h240, 1, 32'h600, 0, 32'h0);
      rst = 1;
      tick();
      rst = 0;
      idle_e();
      pcF = 32'h200;
      #1;
      chk("rst_mid_200_miss", {31'd0, pred_takenF}, 32'd0);
      chk("rst_mid_200_tgt", pred_targetF, 32'h204);
      pcF = 32'h240;
      #1;
      chk("rst_mid_240_miss", {31'd0, pred_takenF}, 32'd0);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
